// File: rtl/food_placer_pkg.sv
// -----------------------------------------------------------------------------
// food_placer_pkg
// Shared definitions for the snake-game food placer: default board geometry,
// coordinate widths, the food_placer state encoding and a coordinate type.
//
// Optional feature macro used by the importing files: FOOD_SCAN_FALLBACK_EN
// (the SCAN state codes below are only reached when it is defined).
// -----------------------------------------------------------------------------
package food_placer_pkg;

    // Default board geometry (columns x rows) and try budget.
    localparam int DEF_BOARD_WIDTH  = 40;
    localparam int DEF_BOARD_HEIGHT = 30;
    localparam int DEF_MAX_TRIES    = 64;

    // Coordinate widths shared with the rng and the occupancy RAM.
    localparam int X_W = 6;
    localparam int Y_W = 5;

    // food_placer state encoding.
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SAMPLE     = 3'd1;
    localparam logic [2:0] S_READ       = 3'd2;
    localparam logic [2:0] S_CHECK      = 3'd3;
    localparam logic [2:0] S_SCAN_READ  = 3'd4;
    localparam logic [2:0] S_SCAN_CHECK = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    // One board cell.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_t;

    // True when the cell lies on the board (x_last/y_last are the last legal
    // column/row). The rng may produce values past the board edge.
    function automatic logic coord_in_board(input coord_t         c,
                                            input logic [X_W-1:0] x_last,
                                            input logic [Y_W-1:0] y_last);
        return (c.x <= x_last) && (c.y <= y_last);
    endfunction

endpackage

// File: rtl/food_cand_counter.sv
// -----------------------------------------------------------------------------
// food_cand_counter
// Row-major scan stepper used by the food placer's deterministic fallback.
// Given the current scan cell it produces the next cell (x advances, wrapping
// to 0 and bumping y at the last column) and flags the last board cell.
// Only compiled when FOOD_SCAN_FALLBACK_EN is defined.
//
// Ports:
//   i_cur   in   current scan cell
//   o_next  out  next scan cell in row-major order
//   o_last  out  i_cur is the bottom-right board cell
// -----------------------------------------------------------------------------
`ifdef FOOD_SCAN_FALLBACK_EN
module food_cand_counter
    import food_placer_pkg::*;
#(
    parameter int BOARD_WIDTH  = DEF_BOARD_WIDTH,
    parameter int BOARD_HEIGHT = DEF_BOARD_HEIGHT
) (
    input  coord_t i_cur,
    output coord_t o_next,
    output logic   o_last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(BOARD_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(BOARD_HEIGHT - 1);

    logic w_row_end;

    assign w_row_end = (i_cur.x == X_LAST);
    assign o_last    = w_row_end && (i_cur.y == Y_LAST);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned (no latch).
    always_comb begin
        o_next = i_cur;
        if (w_row_end) begin
            o_next.x = '0;
            o_next.y = i_cur.y + 1'b1;
        end else begin
            o_next.x = i_cur.x + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/food_placer.sv
// -----------------------------------------------------------------------------
// food_placer
// Picks a free board cell for new food. On a place_req pulse it samples
// (rand_x, rand_y) from the free-running rng, reads the occupancy RAM for that
// cell and retries until it finds a free on-board cell or runs out of tries.
// Each random try costs three cycles: SAMPLE -> READ -> CHECK.
//
// Optional feature: FOOD_SCAN_FALLBACK_EN. When defined, running out of random
// tries starts a row-major scan of the whole board from (0,0); a full board
// ends in a fail pulse with food_valid cleared. When undefined, running out of
// tries pulses fail and leaves the previous food untouched.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   place_req    in   one-cycle placement request (ignored while busy)
//   rand_x/y     in   random candidate from the rng
//   occ_rd_x/y   out  occupancy RAM read address (the candidate register)
//   occ_rd_data  in   occupied flag, valid one cycle after the address
//   food_x/y     out  committed food cell
//   food_valid   out  food_x/y hold a placed food
//   busy         out  search in progress
//   done         out  one-cycle pulse: placement committed
//   fail         out  one-cycle pulse: no free cell found
// -----------------------------------------------------------------------------
module food_placer
    import food_placer_pkg::*;
#(
    parameter int BOARD_WIDTH  = DEF_BOARD_WIDTH,
    parameter int BOARD_HEIGHT = DEF_BOARD_HEIGHT,
    parameter int MAX_TRIES    = DEF_MAX_TRIES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           place_req,
    input  logic [X_W-1:0] rand_x,
    input  logic [Y_W-1:0] rand_y,
    output logic [X_W-1:0] occ_rd_x,
    output logic [Y_W-1:0] occ_rd_y,
    input  logic           occ_rd_data,
    output logic [X_W-1:0] food_x,
    output logic [Y_W-1:0] food_y,
    output logic           food_valid,
    output logic           busy,
    output logic           done,
    output logic           fail
);

    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(BOARD_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(BOARD_HEIGHT - 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    logic [2:0]       r_state;
    coord_t           r_cand;
    coord_t           r_food;
    logic             r_food_valid;
    logic             r_fail;
    logic [TRY_W-1:0] r_tries;

    logic             w_cand_free;

    // The RAM does no bounds checking, so an off-board rng value must be
    // rejected here as if it were occupied.
    assign w_cand_free = !occ_rd_data && coord_in_board(r_cand, X_LAST, Y_LAST);

`ifdef FOOD_SCAN_FALLBACK_EN
    coord_t w_scan_next;
    logic   w_scan_last;

    food_cand_counter #(
        .BOARD_WIDTH  (BOARD_WIDTH),
        .BOARD_HEIGHT (BOARD_HEIGHT)
    ) u_cand_counter (
        .i_cur  (r_cand),
        .o_next (w_scan_next),
        .o_last (w_scan_last)
    );
`endif

    // NOTE: state registers use non-blocking assignments only, so every
    // register sees the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cand       <= '0;
            r_food       <= '0;
            r_food_valid <= 1'b0;
            r_fail       <= 1'b0;
            r_tries      <= '0;
        end else begin
            r_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (place_req) begin
                        r_tries <= '0;
                        r_state <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
                    r_cand.x <= rand_x;
                    r_cand.y <= rand_y;
                    r_state  <= S_READ;
                end

                // Address is on occ_rd_x/y this cycle; the RAM registers it.
                S_READ: r_state <= S_CHECK;

                S_CHECK: begin
                    if (w_cand_free) begin
                        r_food       <= r_cand;
                        r_food_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (r_tries == TRY_LAST) begin
                        r_tries <= r_tries + 1'b1;
`ifdef FOOD_SCAN_FALLBACK_EN
                        r_cand  <= '0;
                        r_state <= S_SCAN_READ;
`else
                        r_fail  <= 1'b1;
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_tries <= r_tries + 1'b1;
                        r_state <= S_SAMPLE;
                    end
                end

`ifdef FOOD_SCAN_FALLBACK_EN
                S_SCAN_READ: r_state <= S_SCAN_CHECK;

                // Scan cells are always on the board, so only the RAM flag
                // matters here.
                S_SCAN_CHECK: begin
                    if (!occ_rd_data) begin
                        r_food       <= r_cand;
                        r_food_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (w_scan_last) begin
                        r_fail       <= 1'b1;
                        r_food_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cand  <= w_scan_next;
                        r_state <= S_SCAN_READ;
                    end
                end
`endif

                S_DONE: r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign occ_rd_x   = r_cand.x;
    assign occ_rd_y   = r_cand.y;
    assign food_x     = r_food.x;
    assign food_y     = r_food.y;
    assign food_valid = r_food_valid;
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign fail       = r_fail;

endmodule

// File: tb/tb_food_placer.sv
// -----------------------------------------------------------------------------
// tb_food_placer
// Self-checking bench for food_placer. The bench owns the occupancy board
// (served through a registered read port) and the rng values. For each
// request, a reference model walks the candidate list (and, with
// FOOD_SCAN_FALLBACK_EN, the row-major board) and queues the expected outcome;
// a monitor pops it whenever done or fail pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_food_placer;

    localparam int W  = 40;
    localparam int H  = 30;
    localparam int MT = 64;
    localparam int WAIT_LIMIT = 3 * MT + 2 * W * H + 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       place_req;
    logic [5:0] rand_x;
    logic [4:0] rand_y;
    logic [5:0] occ_rd_x;
    logic [4:0] occ_rd_y;
    logic       occ_rd_data;
    logic [5:0] food_x;
    logic [4:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       done;
    logic       fail;

    always #5 clk = ~clk;

    food_placer #(
        .BOARD_WIDTH  (W),
        .BOARD_HEIGHT (H),
        .MAX_TRIES    (MT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .place_req   (place_req),
        .rand_x      (rand_x),
        .rand_y      (rand_y),
        .occ_rd_x    (occ_rd_x),
        .occ_rd_y    (occ_rd_y),
        .occ_rd_data (occ_rd_data),
        .food_x      (food_x),
        .food_y      (food_y),
        .food_valid  (food_valid),
        .busy        (busy),
        .done        (done),
        .fail        (fail)
    );

    // Board: cells off the board are never marked, so the RAM reports them
    // free and the DUT must reject them on its own.
    bit occ [64][32];
    always @(posedge clk) occ_rd_data <= occ[occ_rd_x][occ_rd_y];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Candidate list handed to the DUT, one per try.
    logic [5:0] cx [MT];
    logic [4:0] cy [MT];
    int         req_cyc   = 0;
    bit         search_on = 1'b0;

    // rng: try k is sampled in the cycle 3k+1 after the request cycle; all
    // other cycles carry unrelated random values.
    int rel_r;
    always @(posedge clk) begin
        #1;
        rel_r = cyc - req_cyc;
        if (search_on && rel_r >= 1 && (rel_r - 1) % 3 == 0 && (rel_r - 1) / 3 < MT) begin
            rand_x = cx[(rel_r - 1) / 3];
            rand_y = cy[(rel_r - 1) / 3];
        end else begin
            rand_x = 6'($urandom);
            rand_y = 5'($urandom);
        end
    end

    typedef struct {
        bit         is_done;
        int         lat;
        logic [5:0] fx;
        logic [4:0] fy;
        logic       fv;
    } exp_t;

    exp_t exp_q[$];

    // Model of the committed food registers.
    logic [5:0] m_fx = '0;
    logic [4:0] m_fy = '0;
    logic       m_fv = 1'b0;

    // Monitor.
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset === 1'b0 && (done === 1'b1 || fail === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("spurious_pulse", {30'd0, done, fail}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {30'd0, done, fail}, mon_e.is_done ? 32'd2 : 32'd1);
                check("pulse_latency", cyc - req_cyc, mon_e.lat);
                check("food_x", food_x, mon_e.fx);
                check("food_y", food_y, mon_e.fy);
                check("food_valid", food_valid, mon_e.fv);
                check("busy_at_pulse", busy, 0);
            end
        end
    end

    task automatic fill_board(input int pct);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                occ[x][y] = (x < W && y < H) ? ($urandom_range(0, 99) < pct) : 1'b0;
    endtask

    task automatic random_cands();
        for (int k = 0; k < MT; k++) begin
            cx[k] = 6'($urandom);
            cy[k] = 5'($urandom);
        end
    endtask

    // Predict, request, and wait for the monitor to consume the outcome.
    task automatic search(input string tag, input int busy_req_rel);
        exp_t e;
        bit   found = 1'b0;
        e.lat = 0;
        for (int k = 0; k < MT && !found; k++) begin
            if (cx[k] < W && cy[k] < H && !occ[cx[k]][cy[k]]) begin
                found = 1'b1;
                e.lat = 3 * k + 4;
                m_fx = cx[k];
                m_fy = cy[k];
                m_fv = 1'b1;
            end
        end
        if (!found) begin
`ifdef FOOD_SCAN_FALLBACK_EN
            for (int i = 0; i < W * H && !found; i++) begin
                if (!occ[i % W][i / W]) begin
                    found = 1'b1;
                    e.lat = 3 * MT + 3 + 2 * i;
                    m_fx = 6'(i % W);
                    m_fy = 5'(i / W);
                    m_fv = 1'b1;
                end
            end
            if (!found) begin
                e.lat = 3 * MT + 3 + 2 * (W * H - 1);
                m_fv  = 1'b0;
            end
`else
            e.lat = 3 * MT + 1;
`endif
        end
        e.is_done = found;
        e.fx = m_fx;
        e.fy = m_fy;
        e.fv = m_fv;

        @(posedge clk); #1;
        req_cyc   = cyc;
        search_on = 1'b1;
        exp_q.push_back(e);
        place_req = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            @(posedge clk); #1;
            place_req = (r == busy_req_rel);
            if (r == 2) begin
                check({tag, "_rd_x"}, occ_rd_x, cx[0]);
                check({tag, "_rd_y"}, occ_rd_y, cy[0]);
                check({tag, "_busy"}, busy, 1);
            end
        end
        @(posedge clk); #1;
        place_req = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            check({tag, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        search_on = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        place_req = 1'b1;   // reset must win over a simultaneous request
        fill_board(0);
        random_cands();
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        place_req = 1'b0;
        @(posedge clk); #1;
        check("rst_food_x", food_x, 0);
        check("rst_food_y", food_y, 0);
        check("rst_food_valid", food_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_rd_x", occ_rd_x, 0);
        check("rst_rd_y", occ_rd_y, 0);

        // Empty board, first candidate wins.
        fill_board(0);
        random_cands();
        cx[0] = 6'd12; cy[0] = 5'd7;
        search("empty", 0);

        // One occupied, one off-board, then a free cell.
        fill_board(0);
        occ[5][5] = 1'b1;
        random_cands();
        cx[0] = 6'd5;  cy[0] = 5'd5;
        cx[1] = 6'd41; cy[1] = 5'd3;
        cx[2] = 6'd20; cy[2] = 5'd10;
        search("reject2", 0);

        // Place at (8,8), then exhaust on a full board.
        fill_board(0);
        random_cands();
        cx[0] = 6'd8; cy[0] = 5'd8;
        search("place88", 0);
        fill_board(100);
        random_cands();
        search("full", 0);

        // Everything occupied except (3,1); rng never offers (3,1).
        fill_board(100);
        occ[3][1] = 1'b0;
        random_cands();
        for (int k = 0; k < MT; k++)
            if (cx[k] == 6'd3 && cy[k] == 5'd1) cx[k] = 6'd4;
        search("one_hole", 0);

        // A request while busy must not start a second search.
        fill_board(0);
        random_cands();
        cx[0] = 6'd50; cy[0] = 5'd2;
        cx[1] = 6'd45; cy[1] = 5'd31;
        cx[2] = 6'd1;  cy[2] = 5'd2;
        search("busy_req", 2);

        // Randomised boards and candidate streams.
        for (int t = 0; t < 8; t++) begin
            fill_board((t == 7) ? 99 : int'($urandom_range(0, 95)));
            random_cands();
            search("rand", (t % 2 == 0) ? 3 : 0);
        end

        // Reset while the first candidate is in CHECK, with a request alongside.
        fill_board(0);
        random_cands();
        cx[0] = 6'd10; cy[0] = 5'd10;
        @(posedge clk); #1;
        req_cyc   = cyc;
        search_on = 1'b1;
        place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset     = 1'b1;
        place_req = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        place_req = 1'b0;
        search_on = 1'b0;
        m_fx = '0; m_fy = '0; m_fv = 1'b0;
        check("mid_rst_food_x", food_x, 0);
        check("mid_rst_food_y", food_y, 0);
        check("mid_rst_food_valid", food_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_fail", fail, 0);
        check("mid_rst_rd_x", occ_rd_x, 0);
        check("mid_rst_rd_y", occ_rd_y, 0);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);

        // Normal operation resumes after the reset.
        fill_board(30);
        random_cands();
        search("after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
